// File: rtl/avl_bus_traffic_checker.sv
// Avalon-MM traffic generator/self-checker: writes a seeded pattern over an address window, reads it back and compares.
// Latency: first avm_write one cycle after start; one command per cycle with no stalls; reads pipelined up to MAX_OUTSTANDING.
// Backpressure: commands are held stable while avm_waitrequest=1; reads throttle when MAX_OUTSTANDING are in flight.
// Ports: clk/rest (async active-high), start/busy/done, result flags pass/timeout/err_count/first_err_*, Avalon-MM master avm_*.
module avl_bus_traffic_checker #(
  parameter int          ADDR_W          = 32,
  parameter int          DATA_W          = 32,
  parameter logic [31:0] BASE_ADDR       = 32'h8000_0000,
  parameter int          NUM_WORDS       = 256,
  parameter int          STRIDE          = 4,
  parameter int          MODE            = 0,
  parameter int          MAX_OUTSTANDING = 4,
  parameter int          TIMEOUT         = 1024,
  parameter logic [31:0] SEED            = 32'h5A5A_A5A5
) (
  input  logic                clk,
  input  logic                rest,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                timeout,
  output logic [15:0]         err_count,
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic [DATA_W-1:0]   first_err_data,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic                avm_waitrequest,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_readdatavalid
);

  localparam int IW = $clog2(NUM_WORDS + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_DRAIN, S_FIN} state_t;

  state_t            state, nxt;
  logic [IW-1:0]     idx;
  logic [OW-1:0]     outst;
  logic [PW-1:0]     wp, rp;
  logic [TW-1:0]     tcnt;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_data;
  logic [31:0]       pat32;
  logic              rd_acc, wr_acc, push, pop, last, to_hit, mism;
  logic [ADDR_W-1:0] err_addr;

  // Expected data plus its address, so a mismatch can report where it happened.
  logic [DATA_W-1:0] fifo_dat [2**PW];
  logic [ADDR_W-1:0] fifo_adr [2**PW];

  assign cur_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(idx) * ADDR_W'(STRIDE);
  assign pat32    = 32'(cur_addr) ^ SEED;

  // Replicate the 32-bit pattern across the bus; odd words are inverted to catch stuck data lines.
  always_comb begin
    cur_data = '0;
    for (int b = 0; b < DATA_W; b++) begin
      cur_data[b] = pat32[b[4:0]] ^ idx[0];
    end
  end

  assign last   = (idx == IW'(NUM_WORDS - 1));
  assign to_hit = (state == S_WR || state == S_RD || state == S_DRAIN) && (tcnt == TW'(TIMEOUT));
  assign rd_acc = avm_read & ~avm_waitrequest;
  assign wr_acc = avm_write & ~avm_waitrequest;
  assign push   = rd_acc;
  assign pop    = avm_readdatavalid && (outst != '0);

  // State register
  always_ff @(posedge clk or posedge rest) begin
    if (rest) state <= S_IDLE;
    else      state <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (start) nxt = S_WR;
      S_WR:    if (wr_acc) nxt = (MODE == 0 && !last) ? S_WR : S_RD;
      S_RD:    if (rd_acc) begin
                 if (last)           nxt = S_DRAIN;
                 else if (MODE != 0) nxt = S_WR;
               end
      S_DRAIN: if (outst == '0) nxt = S_FIN;
      S_FIN:   nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    if (to_hit) nxt = S_FIN;
  end

  // Output logic; address/data are driven only alongside a request so the bus reads zero when idle.
  always_comb begin
    avm_read       = (state == S_RD) && (outst < OW'(MAX_OUTSTANDING)) && !to_hit;
    avm_write      = (state == S_WR) && !to_hit;
    avm_address    = (avm_read || avm_write) ? cur_addr : '0;
    avm_writedata  = avm_write ? cur_data : '0;
    avm_byteenable = '1;
    busy           = (state != S_IDLE);
    done           = (state == S_FIN);
  end

  // Word index and read pipeline bookkeeping
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      idx   <= '0;
      outst <= '0;
      wp    <= '0;
      rp    <= '0;
      tcnt  <= '0;
    end else begin
      if (state == S_IDLE && start) idx <= '0;
      else if (wr_acc && MODE == 0) idx <= last ? '0 : idx + 1'b1;
      else if (rd_acc)              idx <= idx + 1'b1;

      if (to_hit) begin
        outst <= '0;
        wp    <= '0;
        rp    <= '0;
        tcnt  <= '0;
      end else begin
        outst <= outst + OW'(push) - OW'(pop);
        if (push) wp <= (wp == PW'(MAX_OUTSTANDING - 1)) ? '0 : wp + 1'b1;
        if (pop)  rp <= (rp == PW'(MAX_OUTSTANDING - 1)) ? '0 : rp + 1'b1;
        // Watchdog only runs while responses are owed and none are arriving.
        if (outst == '0 || avm_readdatavalid) tcnt <= '0;
        else                                  tcnt <= tcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_dat[wp] <= cur_data;
      fifo_adr[wp] <= cur_addr;
    end
  end

  // A response with nothing expected is an error reported at address 0.
  assign mism     = avm_readdatavalid && ((outst == '0) || (avm_readdata != fifo_dat[rp]));
  assign err_addr = (outst == '0) ? '0 : fifo_adr[rp];

  // Result registers
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      pass           <= 1'b0;
      timeout        <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
    end else if (state == S_IDLE && start) begin
      pass           <= 1'b0;
      timeout        <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
    end else begin
      if (mism) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 1'b1;
        if (err_count == '0) begin
          first_err_addr <= err_addr;
          first_err_data <= avm_readdata;
        end
      end
      if (to_hit)          timeout <= 1'b1;
      if (state == S_FIN)  pass    <= (err_count == '0) && !timeout;
    end
  end

endmodule

// File: tb/tb_avl_bus_traffic_checker.sv
// Bench for avl_bus_traffic_checker: MODE 0 instance against a behavioural slave with optional
// stalls, random latency, corruption and dropped responses; MODE 1 instance against a zero-wait RAM.
module tb_avl_bus_traffic_checker;

  logic clk = 1'b0;
  logic rest = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    logic [31:0] a;
    logic [31:0] inv;
    a   = 32'h8000_0000 + 32'(i) * 32'd4;
    inv = (i % 2 == 1) ? 32'hFFFF_FFFF : 32'h0;
    return (a ^ 32'h5A5A_A5A5) ^ inv;
  endfunction

  // ---------------- MODE 0 instance ----------------
  logic        start = 1'b0;
  logic        busy, done, pass, timeout;
  logic [15:0] err_count;
  logic [31:0] first_err_addr, first_err_data;
  logic [31:0] avm_address, avm_writedata, s_rdata;
  logic        avm_read, avm_write, s_wait, s_rdv;
  logic [3:0]  avm_byteenable;

  avl_bus_traffic_checker #(.NUM_WORDS(16), .MAX_OUTSTANDING(4), .TIMEOUT(32), .MODE(0)) u0 (
    .clk(clk), .rest(rest), .start(start), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .err_count(err_count), .first_err_addr(first_err_addr),
    .first_err_data(first_err_data), .avm_address(avm_address), .avm_read(avm_read),
    .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(s_wait), .avm_readdata(s_rdata), .avm_readdatavalid(s_rdv)
  );

  // ---------------- MODE 1 instance ----------------
  logic        start1 = 1'b0;
  logic        m1_busy, m1_done, m1_pass, m1_timeout, m1_read, m1_write, m1_rdv;
  logic [15:0] m1_err;
  logic [31:0] m1_fea, m1_fed, m1_address, m1_writedata, m1_rdata;
  logic [3:0]  m1_be;

  avl_bus_traffic_checker #(.NUM_WORDS(8), .MODE(1)) u1 (
    .clk(clk), .rest(rest), .start(start1), .busy(m1_busy), .done(m1_done), .pass(m1_pass),
    .timeout(m1_timeout), .err_count(m1_err), .first_err_addr(m1_fea),
    .first_err_data(m1_fed), .avm_address(m1_address), .avm_read(m1_read),
    .avm_write(m1_write), .avm_writedata(m1_writedata), .avm_byteenable(m1_be),
    .avm_waitrequest(1'b0), .avm_readdata(m1_rdata), .avm_readdatavalid(m1_rdv)
  );

  // ---------------- slave model for u0 ----------------
  typedef struct { int due; int widx; logic [31:0] d; } rsp_t;
  rsp_t        rq[$];
  logic [31:0] mem [64];
  int cyc = 0, last_due = 0;
  bit wait_rand = 0, lat_rand = 0;
  int fixed_lat = 1, corrupt_idx = -1, swallow_idx = -1;

  function automatic int widx_of(input logic [31:0] a);
    return int'(((a - 32'h8000_0000) >> 2) & 32'd63);
  endfunction

  always @(posedge clk or posedge rest) begin
    if (rest) begin
      rq.delete();
      last_due = cyc;
      s_wait  <= 1'b0;
      s_rdv   <= 1'b0;
      s_rdata <= '0;
    end else begin
      rsp_t r;
      int lat;
      cyc++;
      if (avm_write && !s_wait) mem[widx_of(avm_address)] = avm_writedata;
      if (avm_read && !s_wait) begin
        lat   = lat_rand ? int'($urandom_range(1, 8)) : fixed_lat;
        r.due = cyc + lat - 1;
        if (r.due <= last_due) r.due = last_due + 1;
        last_due = r.due;
        r.widx = widx_of(avm_address);
        r.d    = mem[r.widx];
        if (r.widx == corrupt_idx) r.d = r.d ^ 32'h1;
        rq.push_back(r);
      end
      s_rdv <= 1'b0;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        r = rq.pop_front();
        if (r.widx != swallow_idx) begin
          s_rdv   <= 1'b1;
          s_rdata <= r.d;
        end
      end
      s_wait <= wait_rand ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // ---------------- zero-wait RAM for u1 ----------------
  logic [31:0] mem1 [8];
  always @(posedge clk or posedge rest) begin
    if (rest) begin
      m1_rdv   <= 1'b0;
      m1_rdata <= '0;
    end else begin
      m1_rdv <= 1'b0;
      if (m1_write) mem1[(m1_address >> 2) & 32'd7] <= m1_writedata;
      if (m1_read) begin
        m1_rdv   <= 1'b1;
        m1_rdata <= mem1[(m1_address >> 2) & 32'd7];
      end
    end
  end

  // ---------------- scoreboards and monitors ----------------
  typedef struct { bit wr; logic [31:0] addr; logic [31:0] data; } cmd_t;
  cmd_t exp_q[$];
  cmd_t exp1_q[$];
  logic [31:0] wlog [2];
  int m_out = 0, done_cnt = 0, done1_cnt = 0, ncyc = 0, last_rdv = 0, done_cyc = 0;
  bit prev_stall = 0, p_rd, p_wr;
  logic [31:0] p_addr, p_data;

  always @(negedge clk) begin
    ncyc++;
    if (rest) begin
      m_out      = 0;
      prev_stall = 0;
    end else begin
      cmd_t c;
      if (avm_read || avm_write) check("rd_wr_exclusive", avm_read & avm_write, 1'b0);
      if (prev_stall) begin
        check("hold_addr", avm_address, p_addr);
        check("hold_req", {avm_read, avm_write}, {p_rd, p_wr});
        check("hold_data", avm_writedata, p_data);
      end
      prev_stall = (avm_read || avm_write) && s_wait;
      p_rd = avm_read; p_wr = avm_write; p_addr = avm_address; p_data = avm_writedata;
      if ((avm_read || avm_write) && !s_wait) begin
        check("sb_cmd_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          c = exp_q.pop_front();
          check("sb_cmd_kind", avm_write, c.wr);
          check("sb_cmd_addr", avm_address, c.addr);
          if (c.wr) check("sb_wdata", avm_writedata, c.data);
        end
        if (avm_write && widx_of(avm_address) < 2) wlog[widx_of(avm_address)] = avm_writedata;
        if (avm_read) begin
          m_out++;
          check("outstanding_le4", m_out <= 4, 1'b1);
        end
      end
      if (s_rdv) begin
        if (m_out > 0) m_out--;
        last_rdv = ncyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = ncyc;
        m_out = 0;
      end
      if (m1_read || m1_write) begin
        check("m1_cmd_expected", exp1_q.size() > 0, 1'b1);
        if (exp1_q.size() > 0) begin
          c = exp1_q.pop_front();
          check("m1_cmd_kind", m1_write, c.wr);
          check("m1_cmd_addr", m1_address, c.addr);
          if (c.wr) check("m1_wdata", m1_writedata, c.data);
        end
      end
      if (m1_done) done1_cnt++;
    end
  end

  task automatic push_mode0();
    cmd_t c;
    for (int i = 0; i < 16; i++) begin
      c.wr = 1; c.addr = 32'h8000_0000 + 32'(i * 4); c.data = pat(i);
      exp_q.push_back(c);
    end
    for (int i = 0; i < 16; i++) begin
      c.wr = 0; c.addr = 32'h8000_0000 + 32'(i * 4); c.data = '0;
      exp_q.push_back(c);
    end
  endtask

  // Pulses start, optionally re-pulses it at cycle kick while busy, waits (bounded) for done.
  task automatic run_pass(input string tag, input bit chk_lat, input bit chk_sb, input int kick);
    push_mode0();
    done_cnt = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    if (chk_lat) begin
      check({tag, "_first_write_lat"}, avm_write, 1'b1);
      check({tag, "_busy"}, busy, 1'b1);
    end
    for (int n = 0; n < 3000 && done_cnt == 0; n++) begin
      start = (n == kick);
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_done_seen"}, done_cnt, 1);
    repeat (8) @(negedge clk);
    check({tag, "_done_once"}, done_cnt, 1);
    check({tag, "_idle_after"}, busy, 1'b0);
    if (chk_sb) check({tag, "_sb_empty"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_t c;
    // Reset values
    #2;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_err", err_count, 16'h0);
    check("rst_fea", first_err_addr, 32'h0);
    check("rst_fed", first_err_data, 32'h0);
    check("rst_bus", {avm_read, avm_write, avm_address, avm_writedata}, '0);
    check("rst_be", avm_byteenable, 4'hF);
    repeat (3) @(negedge clk);
    rest = 1'b0;
    @(negedge clk);

    // A: zero wait, 1-cycle latency, with a start pulse while busy
    run_pass("A", 1'b1, 1'b1, 3);
    check("A_pass", pass, 1'b1);
    check("A_err", err_count, 16'h0);
    check("A_timeout", timeout, 1'b0);
    check("A_word0", wlog[0], 32'hDA5A_A5A5);
    check("A_word1", wlog[1], 32'h25A5_5A5E);

    // B: slave flips bit 0 of word 5
    corrupt_idx = 5;
    run_pass("B", 1'b0, 1'b1, -1);
    corrupt_idx = -1;
    check("B_err", err_count, 16'h1);
    check("B_fea", first_err_addr, 32'h8000_0014);
    check("B_fed", first_err_data, pat(5) ^ 32'h1);
    check("B_pass", pass, 1'b0);

    // C: random stalls and random read latency
    wait_rand = 1; lat_rand = 1;
    run_pass("C", 1'b0, 1'b1, -1);
    wait_rand = 0; lat_rand = 0;
    check("C_pass", pass, 1'b1);
    check("C_err", err_count, 16'h0);
    check("C_fea_cleared", first_err_addr, 32'h0);

    // D: third read response swallowed
    swallow_idx = 2;
    run_pass("D", 1'b0, 1'b0, -1);
    swallow_idx = -1;
    check("D_timeout", timeout, 1'b1);
    check("D_pass", pass, 1'b0);
    check("D_err_nonzero", err_count != 16'h0, 1'b1);
    check("D_gap", (done_cyc - last_rdv >= 30) && (done_cyc - last_rdv <= 40), 1'b1);
    check("D_bus_idle", {avm_read, avm_write}, 2'b00);

    // E: reset with two reads outstanding, then a clean pass
    fixed_lat = 8;
    push_mode0();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int n = 0; n < 200 && m_out < 2; n++) @(negedge clk);
    check("E_two_outstanding", m_out, 2);
    rest = 1'b1;
    #1;
    check("E_rst_busy", busy, 1'b0);
    check("E_rst_bus", {avm_read, avm_write, avm_address, avm_writedata}, '0);
    check("E_rst_be", avm_byteenable, 4'hF);
    check("E_rst_flags", {done, pass, timeout, err_count}, '0);
    @(negedge clk);
    rest = 1'b0;
    exp_q.delete();
    fixed_lat = 1;
    @(negedge clk);
    run_pass("F", 1'b1, 1'b1, -1);
    check("F_pass", pass, 1'b1);
    check("F_err", err_count, 16'h0);
    check("F_timeout", timeout, 1'b0);

    // M1: interleaved mode, command order W0 R0 ... W7 R7
    for (int i = 0; i < 8; i++) begin
      c.wr = 1; c.addr = 32'h8000_0000 + 32'(i * 4); c.data = pat(i);
      exp1_q.push_back(c);
      c.wr = 0; c.data = '0;
      exp1_q.push_back(c);
    end
    done1_cnt = 0;
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    for (int n = 0; n < 500 && done1_cnt == 0; n++) @(negedge clk);
    repeat (4) @(negedge clk);
    check("M1_done_once", done1_cnt, 1);
    check("M1_sb_empty", exp1_q.size(), 0);
    check("M1_pass", m1_pass, 1'b1);
    check("M1_err", m1_err, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
